// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: sequencing controller for a 16x-oversampling UART receiver.
// Generates the oversample tick, gates reception with rx_en, buffers completed
// bytes in a show-ahead FIFO drained over valid/ready, and flags overrun and
// character timeout.
// Optional break detector: define UART_RX_CTRL_BREAK_DET_EN to add din/brk.
module uart_rx_ctrl #(
    parameter int unsigned DIV_W    = 11,
    parameter int unsigned DIV_RST  = 650,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned TO_TICKS = 640
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_we,
    input  logic [DIV_W-1:0]         cfg_div,
    input  logic                     rx_en,
    output logic                     tick,
    input  logic                     rx_done,
    input  logic [7:0]               rx_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [7:0]               m_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overrun,
    output logic                     timeout_irq,
    input  logic                     clr_err
`ifdef UART_RX_CTRL_BREAK_DET_EN
    ,
    input  logic                     din,
    output logic                     brk
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned TW = $clog2(TO_TICKS + 1);

    typedef enum logic [1:0] {
        S_OFF = 2'd0,
        S_RUN = 2'd1,
        S_TMO = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [DIV_W-1:0]  r_div;
    logic [DIV_W-1:0]  r_cnt;
    logic              r_tick;
    logic [TW-1:0]     r_to_cnt;
    logic              r_irq;
    logic              r_ovr;
    logic [7:0]        r_mem [DEPTH];
    logic [AW-1:0]     r_wptr;
    logic [AW-1:0]     r_rptr;
    logic [LW-1:0]     r_level;

    logic              w_active;
    logic              w_empty;
    logic              w_full;
    logic              w_pop;
    logic              w_push_req;
    logic              w_push;
    logic              w_drop;
    logic              w_brk_sup;

    assign w_active   = (r_state != S_OFF);
    assign w_empty    = (r_level == '0);
    assign w_full     = (r_level == LW'(DEPTH));
    assign w_pop      = !w_empty && m_ready;
    assign w_push_req = rx_done && w_active && !w_brk_sup;
    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_drop     = w_push_req && w_full && !w_pop;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_OFF;
        else     r_state <= w_state_nxt;
    end

    // Next-state logic: enable gating and character-timeout entry/exit.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_OFF: begin
                if (rx_en) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (!rx_en)
                    w_state_nxt = S_OFF;
                else if (r_tick && !w_empty && !w_push && !w_pop &&
                         (r_to_cnt == TW'(TO_TICKS - 1)))
                    w_state_nxt = S_TMO;
            end
            S_TMO: begin
                if (!rx_en)
                    w_state_nxt = S_OFF;
                else if (w_push || w_pop || w_empty)
                    w_state_nxt = S_RUN;
            end
            default: w_state_nxt = S_OFF;
        endcase
    end

    // Baud generator: tick pulses once per divisor+1 clocks, held off while OFF.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div  <= DIV_W'(DIV_RST);
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (cfg_we) begin
            r_div  <= cfg_div;
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (w_state_nxt == S_OFF) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (r_cnt == r_div) begin
            r_cnt  <= '0;
            r_tick <= 1'b1;
        end else begin
            r_cnt  <= r_cnt + DIV_W'(1);
            r_tick <= 1'b0;
        end
    end

    // Timeout counter: saturating tick count of FIFO inactivity while running.
    always_ff @(posedge clk) begin
        if (rst)
            r_to_cnt <= '0;
        else if (!w_active || w_push || w_pop || w_empty)
            r_to_cnt <= '0;
        else if ((r_state == S_RUN) && r_tick && (r_to_cnt != TW'(TO_TICKS - 1)))
            r_to_cnt <= r_to_cnt + TW'(1);
    end

    // Interrupt mirrors the timeout state, aligned with the state register.
    always_ff @(posedge clk) begin
        if (rst) r_irq <= 1'b0;
        else     r_irq <= (w_state_nxt == S_TMO);
    end

    // Sticky overrun; a drop wins over a coincident clear.
    always_ff @(posedge clk) begin
        if (rst)          r_ovr <= 1'b0;
        else if (w_drop)  r_ovr <= 1'b1;
        else if (clr_err) r_ovr <= 1'b0;
    end

    // FIFO storage; contents need no reset since empty reads return zero.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= rx_data;
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

`ifdef UART_RX_CTRL_BREAK_DET_EN
    localparam int unsigned BRK_TICKS = 160;

    logic [7:0] r_brk_cnt;
    logic       r_brk;

    // Pushes are blocked from the tick that completes a break until din recovers.
    assign w_brk_sup = w_active && !din &&
                       ((r_brk_cnt == 8'(BRK_TICKS)) ||
                        (r_tick && (r_brk_cnt == 8'(BRK_TICKS - 1))));

    // Break detector: count low-line ticks, latch brk at ten bit times.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_brk_cnt <= '0;
            r_brk     <= 1'b0;
        end else begin
            if (!w_active || din)
                r_brk_cnt <= '0;
            else if (r_tick && (r_brk_cnt != 8'(BRK_TICKS)))
                r_brk_cnt <= r_brk_cnt + 8'(1);

            if (w_active && !din && r_tick && (r_brk_cnt == 8'(BRK_TICKS - 1)))
                r_brk <= 1'b1;
            else if (clr_err)
                r_brk <= 1'b0;
        end
    end

    assign brk = r_brk;
`else
    assign w_brk_sup = 1'b0;
`endif

    assign tick        = r_tick;
    assign timeout_irq = r_irq;
    assign overrun     = r_ovr;
    assign level       = r_level;
    assign m_valid     = !w_empty;
    assign m_data      = w_empty ? 8'h00 : r_mem[r_rptr];

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: queue scoreboard for FIFO data, vector table for
// push/pop/overrun, and hand sequences for baud, timeout, reset and break.
module tb_uart_rx_ctrl;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst, cfg_we, rx_en, rx_done, m_ready, clr_err;
    logic [10:0] cfg_div;
    logic [7:0]  rx_data;
    logic        tick, m_valid, overrun, timeout_irq;
    logic [7:0]  m_data;
    logic [2:0]  level;
`ifdef UART_RX_CTRL_BREAK_DET_EN
    logic        din, brk;
`endif

    always #5 clk = ~clk;

    uart_rx_ctrl dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_div(cfg_div), .rx_en(rx_en),
        .tick(tick), .rx_done(rx_done), .rx_data(rx_data), .m_valid(m_valid),
        .m_ready(m_ready), .m_data(m_data), .level(level), .overrun(overrun),
        .timeout_irq(timeout_irq), .clr_err(clr_err)
`ifdef UART_RX_CTRL_BREAK_DET_EN
        , .din(din), .brk(brk)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Scoreboard and reference state.
    byte unsigned sb[$];
    bit           m_ov;
    bit           m_en;
    bit           sup;

    typedef struct {
        bit           done;
        byte unsigned data;
        bit           rdy;
        bit           clr;
        int           lvl;
        bit           ov;
    } vec_t;
    vec_t tbl[18];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock: update the reference from the driven inputs, then compare.
    task automatic cyc();
        bit           pop, full, preq;
        byte unsigned h;
        pop = m_ready && (sb.size() != 0);
        if (rst) begin
            sb.delete();
            m_ov = 1'b0;
            m_en = 1'b0;
        end else begin
            full = (sb.size() == DEPTH);
            preq = rx_done && m_en && !sup;
            if (pop) begin
                h = sb.pop_front();
                chk("pop_data", int'(m_data), int'(h));
            end
            if (preq && (!full || pop)) sb.push_back(rx_data);
            if (preq && full && !pop) m_ov = 1'b1;
            else if (clr_err)         m_ov = 1'b0;
            m_en = rx_en;
        end
        @(posedge clk);
        #1;
        chk("level", int'(level), sb.size());
        chk("m_valid", int'(m_valid), int'(sb.size() != 0));
        if (sb.size() == 0) chk("m_data_empty", int'(m_data), 0);
        else                chk("m_data_head", int'(m_data), int'(sb[0]));
        chk("overrun", int'(overrun), int'(m_ov));
    endtask

    initial begin
        int n;

        tbl[0]  = '{1, 8'h55, 0, 0, 1, 0};
        tbl[1]  = '{1, 8'hA3, 0, 0, 2, 0};
        tbl[2]  = '{0, 8'h00, 1, 0, 1, 0};
        tbl[3]  = '{0, 8'h00, 1, 0, 0, 0};
        tbl[4]  = '{0, 8'h00, 1, 0, 0, 0};
        tbl[5]  = '{1, 8'h01, 0, 0, 1, 0};
        tbl[6]  = '{1, 8'h02, 0, 0, 2, 0};
        tbl[7]  = '{1, 8'h03, 0, 0, 3, 0};
        tbl[8]  = '{1, 8'h04, 0, 0, 4, 0};
        tbl[9]  = '{1, 8'h05, 0, 0, 4, 1};
        tbl[10] = '{1, 8'h06, 1, 0, 4, 1};
        tbl[11] = '{0, 8'h00, 0, 1, 4, 0};
        tbl[12] = '{1, 8'h07, 0, 1, 4, 1};
        tbl[13] = '{0, 8'h00, 0, 1, 4, 0};
        tbl[14] = '{0, 8'h00, 1, 0, 3, 0};
        tbl[15] = '{0, 8'h00, 1, 0, 2, 0};
        tbl[16] = '{0, 8'h00, 1, 0, 1, 0};
        tbl[17] = '{0, 8'h00, 1, 0, 0, 0};

        rst = 1'b1; cfg_we = 1'b0; cfg_div = '0; rx_en = 1'b0; rx_done = 1'b0;
        rx_data = '0; m_ready = 1'b0; clr_err = 1'b0; sup = 1'b0;
        m_ov = 1'b0; m_en = 1'b0;
`ifdef UART_RX_CTRL_BREAK_DET_EN
        din = 1'b1;
`endif
        cyc();
        // rx_done during reset must not be captured
        rx_done = 1'b1; rx_data = 8'h99;
        cyc();
        rx_done = 1'b0;
        chk("rst_tick", int'(tick), 0);
        chk("rst_irq", int'(timeout_irq), 0);
        rst = 1'b0;
        cyc();

        // Reset divisor: first tick 651 clocks after enable, then every 651
        rx_en = 1'b1;
        n = 0;
        do begin cyc(); n++; end while (!tick && n < 2000);
        chk("first_tick", n, 651);
        cyc();
        chk("tick_width", int'(tick), 0);
        n = 1;
        do begin cyc(); n++; end while (!tick && n < 2000);
        chk("tick_period", n, 651);

        // Divisor 3: tick every 4 clocks
        cfg_we = 1'b1; cfg_div = 11'd3;
        cyc();
        cfg_we = 1'b0;
        chk("cfg_tick", int'(tick), 0);
        for (int i = 1; i <= 23; i++) begin
            cyc();
            chk("tick_div3", int'(tick), int'(i % 4 == 0));
        end
        // Reload exactly at terminal count: that tick is lost
        cfg_we = 1'b1;
        cyc();
        cfg_we = 1'b0;
        chk("tick_tc_sup", int'(tick), 0);
        for (int i = 1; i <= 4; i++) begin
            cyc();
            chk("tick_after_reload", int'(tick), int'(i == 4));
        end

        // Vector table: capture, drain, overrun, set-beats-clear
        foreach (tbl[i]) begin
            rx_done = tbl[i].done; rx_data = tbl[i].data;
            m_ready = tbl[i].rdy;  clr_err = tbl[i].clr;
            cyc();
            chk("vec_level", int'(level), tbl[i].lvl);
            chk("vec_overrun", int'(overrun), int'(tbl[i].ov));
        end
        rx_done = 1'b0; m_ready = 1'b0; clr_err = 1'b0;

        // Timeout: divisor 0, one byte left unread for 640 ticks
        cfg_we = 1'b1; cfg_div = 11'd0;
        cyc();
        cfg_we = 1'b0;
        rx_done = 1'b1; rx_data = 8'h3C;
        cyc();
        rx_done = 1'b0;
        n = 0;
        do begin cyc(); n++; end while (!timeout_irq && n < 2000);
        chk("timeout_ticks", n, 640);
        m_ready = 1'b1;
        cyc();
        m_ready = 1'b0;
        chk("irq_after_pop", int'(timeout_irq), 0);

        rx_done = 1'b1; rx_data = 8'h3D;
        cyc();
        rx_done = 1'b0;
        n = 0;
        do begin cyc(); n++; end while (!timeout_irq && n < 2000);
        chk("timeout_ticks2", n, 640);
        rx_en = 1'b0;
        cyc();
        chk("irq_after_off", int'(timeout_irq), 0);
        chk("tick_off", int'(tick), 0);
        // OFF: ignore rx_done, still drain
        rx_done = 1'b1; rx_data = 8'hEE; m_ready = 1'b1;
        cyc();
        rx_done = 1'b0; m_ready = 1'b0;
        chk("off_drained", int'(level), 0);

        // Reset mid-stream discards FIFO and restores the divisor
        rx_en = 1'b1;
        cyc();
        rx_done = 1'b1; rx_data = 8'h77;
        cyc();
        chk("pre_rst_level", int'(level), 1);
        rst = 1'b1;
        cyc();
        rst = 1'b0; rx_done = 1'b0;
        chk("rst2_level", int'(level), 0);
        chk("rst2_valid", int'(m_valid), 0);
        n = 0;
        do begin cyc(); n++; end while (!tick && n < 2000);
        chk("rst2_first_tick", n, 651);

`ifdef UART_RX_CTRL_BREAK_DET_EN
        // Break: din low for 160 ticks sets brk and blocks a coincident push
        cfg_we = 1'b1; cfg_div = 11'd0;
        cyc();
        cfg_we = 1'b0;
        rx_done = 1'b1; rx_data = 8'h11;
        cyc();
        rx_done = 1'b0;
        din = 1'b0;
        for (int i = 1; i <= 159; i++) cyc();
        chk("brk_early", int'(brk), 0);
        rx_done = 1'b1; rx_data = 8'h22; sup = 1'b1;
        cyc();
        rx_done = 1'b0; sup = 1'b0;
        chk("brk_set", int'(brk), 1);
        chk("brk_level", int'(level), 1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("brk_rst", int'(brk), 0);
        chk("brk_rst_level", int'(level), 0);
        din = 1'b1;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
